// File: rtl/mult_div_unit_if.sv
// Bundle between the decoder/forwarding network and the multiply/divide unit.
// The master side drives the MDU control bundle and operands; the slave side
// (the unit itself) returns Busy and the architectural HI/LO registers.
interface mult_div_unit_if;
  logic        Start;
  logic [2:0]  Op;
  logic        HI_Write;
  logic        LO_Write;
  logic        Req;
  logic [31:0] A;
  logic [31:0] B;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (
    output Start, Op, HI_Write, LO_Write, Req, A, B,
    input  Busy, HI, LO
  );

  modport slave (
    input  Start, Op, HI_Write, LO_Write, Req, A, B,
    output Busy, HI, LO
  );
endinterface

// File: rtl/mult_div_unit.sv
// Execute-stage multiply/divide unit holding HI/LO.
// The result is computed in the accepting cycle and parked in tmp_hi/tmp_lo;
// a down-counter then models the multi-cycle latency before HI/LO update.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | no operation in flight; Start/mthi/mtlo accepted unless Req
// ST_BUSY  | counting down; commits tmp_* to HI/LO when cnt reaches 1
module mult_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic clk,
  input  logic reset,
  mult_div_unit_if.slave bus
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  logic [0:0]  state;
  logic [3:0]  cnt;
  logic [31:0] tmp_hi;
  logic [31:0] tmp_lo;
  logic [31:0] hi_q;
  logic [31:0] lo_q;

  logic        acc;
  logic        is_div;
  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic [31:0] safe_b;
  logic [31:0] quo;
  logic [31:0] rem;
  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [31:0] res_hi;
  logic [31:0] res_lo;

  assign acc      = !bus.Req && (state == ST_IDLE);
  assign bus.Busy = (state == ST_BUSY);
  assign bus.HI   = hi_q;
  assign bus.LO   = lo_q;

  // Full result of the operation presented this cycle; divide by zero keeps HI/LO.
  always_comb begin
    is_div = (bus.Op == 3'd2) || (bus.Op == 3'd3);
    abs_a  = (bus.Op == 3'd2 && bus.A[31]) ? -bus.A : bus.A;
    abs_b  = (bus.Op == 3'd2 && bus.B[31]) ? -bus.B : bus.B;
    // Divisor forced non-zero so the divider never sees 0; the result is discarded then.
    safe_b = (abs_b == 32'd0) ? 32'd1 : abs_b;
    quo    = abs_a / safe_b;
    rem    = abs_a % safe_b;
    prod_s = {{32{bus.A[31]}}, bus.A} * {{32{bus.B[31]}}, bus.B};
    prod_u = {32'd0, bus.A} * {32'd0, bus.B};
    res_hi = prod_s[63:32];
    res_lo = prod_s[31:0];
    case (bus.Op)
      3'd1: begin
        res_hi = prod_u[63:32];
        res_lo = prod_u[31:0];
      end
      3'd2: begin
        if (bus.B == 32'd0) begin
          res_hi = hi_q;
          res_lo = lo_q;
        end else begin
          // Quotient negative when signs differ; remainder follows the dividend.
          // 0x80000000 / -1 wraps back to 0x80000000 with remainder 0.
          res_lo = (bus.A[31] ^ bus.B[31]) ? -quo : quo;
          res_hi = bus.A[31] ? -rem : rem;
        end
      end
      3'd3: begin
        if (bus.B == 32'd0) begin
          res_hi = hi_q;
          res_lo = lo_q;
        end else begin
          res_lo = quo;
          res_hi = rem;
        end
      end
      default: begin
        res_hi = prod_s[63:32];
        res_lo = prod_s[31:0];
      end
    endcase
  end

  // Sequencing: accept start/mthi/mtlo when idle, count down and commit when busy.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      cnt    <= 4'd0;
      tmp_hi <= 32'd0;
      tmp_lo <= 32'd0;
      hi_q   <= 32'd0;
      lo_q   <= 32'd0;
    end else if (state == ST_BUSY) begin
      // Req is deliberately ignored here: it flushes a younger instruction.
      cnt <= cnt - 4'd1;
      if (cnt == 4'd1) begin
        hi_q  <= tmp_hi;
        lo_q  <= tmp_lo;
        state <= ST_IDLE;
      end
    end else if (acc) begin
      if (bus.Start) begin
        tmp_hi <= res_hi;
        tmp_lo <= res_lo;
        state  <= ST_BUSY;
        cnt    <= is_div ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
      end else if (bus.HI_Write) begin
        hi_q <= bus.A;
      end else if (bus.LO_Write) begin
        lo_q <= bus.A;
      end
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: vector table plus hand-written corner sequences.
// Expected HI/LO/latency are queued when an operation starts and checked when
// Busy drops. Inputs change at negedge, outputs are sampled at negedge.
module tb_mult_div_unit;
  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   failed = 0;

  mult_div_unit_if bus();

  mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cycles;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.Start = 1'b0; bus.HI_Write = 1'b0; bus.LO_Write = 1'b0; bus.Req = 1'b0;
  endtask

  // Called at a negedge; presents Start in this cycle and returns at the negedge
  // of the first cycle with Busy low. disturb: 0 none, 1 Req pulse, 2 Start+LO_Write while busy.
  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                        input int disturb);
    exp_t e;
    int   n;
    e.hi = ehi; e.lo = elo;
    e.cycles = (op == 3'd2 || op == 3'd3) ? 10 : 5;
    bus.Start = 1'b1; bus.Op = op; bus.A = a; bus.B = b;
    sb.push_back(e);
    check({name, " busy_in_start_cycle"}, {31'd0, bus.Busy}, 32'd0);
    @(negedge clk);
    idle_inputs();
    n = 0;
    while (bus.Busy && n < 40) begin
      n++;
      idle_inputs();
      if (n == 2 && disturb == 1) bus.Req = 1'b1;
      if (n == 2 && disturb == 2) begin
        bus.Start = 1'b1; bus.LO_Write = 1'b1; bus.Op = 3'd0;
        bus.A = 32'h0000_0099; bus.B = 32'h0000_0099;
      end
      @(negedge clk);
    end
    idle_inputs();
    if (sb.size() == 0) begin
      tests++; failed++;
      $display("FAIL %s: scoreboard empty at completion", name);
    end else begin
      e = sb.pop_front();
      check({name, " busy_cycles"}, n, e.cycles);
      check({name, " HI"}, bus.HI, e.hi);
      check({name, " LO"}, bus.LO, e.lo);
      m_hi = e.hi; m_lo = e.lo;
    end
  endtask

  task automatic mt_write(input bit to_hi, input logic [31:0] v, input bit req);
    bus.HI_Write = to_hi; bus.LO_Write = !to_hi; bus.Req = req; bus.A = v;
    @(negedge clk);
    idle_inputs();
    if (!req) begin
      if (to_hi) m_hi = v; else m_lo = v;
    end
    check(to_hi ? "mthi HI" : "mtlo LO", to_hi ? bus.HI : bus.LO, to_hi ? m_hi : m_lo);
  endtask

  vec_t vecs[11];

  initial begin
    vecs[0]  = '{3'd0, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1};
    vecs[1]  = '{3'd1, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'hFFFF_FFFE};
    vecs[2]  = '{3'd2, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3]  = '{3'd3, 32'd100,       32'd7,         32'd2,         32'd14};
    vecs[4]  = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    vecs[5]  = '{3'd5, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
    vecs[6]  = '{3'd2, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
    vecs[7]  = '{3'd0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000};
    vecs[8]  = '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    vecs[9]  = '{3'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    vecs[10] = '{3'd2, 32'hFFFF_FFF8, 32'd3,         32'hFFFF_FFFE, 32'hFFFF_FFFE};

    idle_inputs();
    bus.Op = 3'd0; bus.A = 32'd0; bus.B = 32'd0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("reset Busy", {31'd0, bus.Busy}, 32'd0);
    check("reset HI", bus.HI, 32'd0);
    check("reset LO", bus.LO, 32'd0);

    // Vector table, issued back-to-back: each start lands in the completion cycle.
    for (int i = 0; i < 11; i++)
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, 0);

    // Divide by zero keeps preloaded HI/LO after a full divide latency.
    @(negedge clk);
    mt_write(1'b1, 32'h0000_1234, 1'b0);
    mt_write(1'b0, 32'h0000_5678, 1'b0);
    run_op("divu_by_zero", 3'd3, 32'd55, 32'd0, m_hi, m_lo, 0);
    run_op("div_by_zero", 3'd2, 32'hFFFF_FF00, 32'd0, m_hi, m_lo, 0);

    // Flushed Start and flushed mthi are dropped.
    bus.Start = 1'b1; bus.Req = 1'b1; bus.Op = 3'd0; bus.A = 32'd3; bus.B = 32'd3;
    @(negedge clk);
    idle_inputs();
    check("flush_start Busy", {31'd0, bus.Busy}, 32'd0);
    @(negedge clk);
    check("flush_start HI", bus.HI, m_hi);
    check("flush_start LO", bus.LO, m_lo);
    mt_write(1'b1, 32'hDEAD_BEEF, 1'b1);

    // Req during flight and strobes during flight do not disturb the result.
    run_op("mult_req_pulse", 3'd0, 32'd6, 32'd7, 32'd0, 32'd42, 1);
    run_op("div_ignored_strobes", 3'd3, 32'd1000, 32'd9, 32'd1, 32'd111, 2);
    run_op("mult_ignored_strobes", 3'd1, 32'd3, 32'd5, 32'd0, 32'd15, 2);

    // Priority: Start beats HI_Write/LO_Write in the same cycle.
    bus.HI_Write = 1'b1; bus.LO_Write = 1'b1;
    run_op("start_priority", 3'd0, 32'd2, 32'd9, 32'd0, 32'd18, 0);
    bus.HI_Write = 1'b1; bus.LO_Write = 1'b1; bus.A = 32'h0000_0ABC;
    @(negedge clk);
    idle_inputs();
    check("hi_priority HI", bus.HI, 32'h0000_0ABC);
    check("hi_priority LO", bus.LO, 32'd18);

    // Reset in the third busy cycle of a divide abandons it.
    bus.Start = 1'b1; bus.Op = 3'd3; bus.A = 32'd100; bus.B = 32'd7;
    @(negedge clk);
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    check("pre_reset Busy", {31'd0, bus.Busy}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid_reset Busy", {31'd0, bus.Busy}, 32'd0);
    check("mid_reset HI", bus.HI, 32'd0);
    check("mid_reset LO", bus.LO, 32'd0);
    repeat (15) @(negedge clk);
    check("no_late_commit Busy", {31'd0, bus.Busy}, 32'd0);
    check("no_late_commit HI", bus.HI, 32'd0);
    check("no_late_commit LO", bus.LO, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
